// File: rtl/light_phase_monitor.sv
// light_phase_monitor
// Watches the lamp drives of a traffic controller, decodes them into a phase
// code and keeps per-phase timing, sequence checking and walk statistics.
module light_phase_monitor (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       Rm,
    input  logic       Ym,
    input  logic       Gm,
    input  logic       Rs,
    input  logic       Ys,
    input  logic       Gs,
    input  logic       W,
    input  logic       err_clear,
    output logic [2:0] phase,
    output logic [3:0] cur_seconds,
    output logic [2:0] last_phase,
    output logic [3:0] last_seconds,
    output logic       phase_done,
    output logic       illegal_combo,
    output logic       illegal_trans,
    output logic [7:0] walk_count
);

    localparam logic [2:0] PH_AR  = 3'd0;
    localparam logic [2:0] PH_MG  = 3'd1;
    localparam logic [2:0] PH_MY  = 3'd2;
    localparam logic [2:0] PH_SG  = 3'd3;
    localparam logic [2:0] PH_SY  = 3'd4;
    localparam logic [2:0] PH_WK  = 3'd5;
    localparam logic [2:0] PH_INV = 3'd7;

    // Lamp patterns in {Rm,Ym,Gm,Rs,Ys,Gs,W} order
    localparam logic [6:0] LAMP_AR = 7'b1001000;
    localparam logic [6:0] LAMP_MG = 7'b0011000;
    localparam logic [6:0] LAMP_MY = 7'b0101000;
    localparam logic [6:0] LAMP_SG = 7'b1000010;
    localparam logic [6:0] LAMP_SY = 7'b1000100;
    localparam logic [6:0] LAMP_WK = 7'b1001001;

    logic [6:0] lamp_q;
    logic       lamp_valid;
    logic       first_update;
    logic [2:0] decoded;
    logic       trans_legal;
    logic       update;
    logic       set_trans;
    logic       set_combo;

    // Stage-1 lamp register; lamp_valid marks that lamp_q holds a real sample
    // rather than its reset value, so the all-dark reset contents never get
    // decoded as an invalid phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lamp_q     <= 7'd0;
            lamp_valid <= 1'b0;
        end else begin
            lamp_q     <= {Rm, Ym, Gm, Rs, Ys, Gs, W};
            lamp_valid <= 1'b1;
        end
    end

    // Decode the registered lamp pattern into a phase code
    always_comb begin
        decoded = PH_INV;
        case (lamp_q)
            LAMP_AR: decoded = PH_AR;
            LAMP_MG: decoded = PH_MG;
            LAMP_MY: decoded = PH_MY;
            LAMP_SG: decoded = PH_SG;
            LAMP_SY: decoded = PH_SY;
            LAMP_WK: decoded = PH_WK;
            default: decoded = PH_INV;
        endcase
    end

    // Is the move from the current phase to the decoded one an allowed step
    always_comb begin
        trans_legal = 1'b0;
        case (phase)
            PH_MG:   trans_legal = (decoded == PH_MY);
            PH_MY:   trans_legal = (decoded == PH_SG) || (decoded == PH_WK);
            PH_WK:   trans_legal = (decoded == PH_SG);
            PH_SG:   trans_legal = (decoded == PH_SY);
            PH_SY:   trans_legal = (decoded == PH_MG);
            PH_AR:   trans_legal = (decoded == PH_MG);
            default: trans_legal = 1'b0;
        endcase
    end

    assign update    = lamp_valid && (decoded != phase);
    assign set_trans = update && !first_update && (phase != PH_INV) && !trans_legal;
    assign set_combo = update && (decoded == PH_INV);

    // Phase register and per-phase timing; a tick on the update edge belongs
    // to the new phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase        <= PH_AR;
            last_phase   <= PH_AR;
            cur_seconds  <= 4'd0;
            last_seconds <= 4'd0;
            phase_done   <= 1'b0;
            first_update <= 1'b1;
        end else if (update) begin
            phase        <= decoded;
            last_phase   <= phase;
            last_seconds <= cur_seconds;
            cur_seconds  <= tick_1hz ? 4'd1 : 4'd0;
            phase_done   <= 1'b1;
            first_update <= 1'b0;
        end else begin
            phase_done <= 1'b0;
            if (tick_1hz && (cur_seconds != 4'd15)) begin
                cur_seconds <= cur_seconds + 4'd1;
            end
        end
    end

    // Sticky error flags; a new set condition beats a simultaneous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_combo <= 1'b0;
            illegal_trans <= 1'b0;
        end else begin
            if (set_combo) begin
                illegal_combo <= 1'b1;
            end else if (err_clear) begin
                illegal_combo <= 1'b0;
            end
            if (set_trans) begin
                illegal_trans <= 1'b1;
            end else if (err_clear) begin
                illegal_trans <= 1'b0;
            end
        end
    end

    // Count entries into the walk phase, saturating
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            walk_count <= 8'd0;
        end else if (update && (decoded == PH_WK) && (walk_count != 8'd255)) begin
            walk_count <= walk_count + 8'd1;
        end
    end

endmodule

// File: doc/light_phase_monitor.md
LIGHT_PHASE_MONITOR -- requirements
Module: light_phase_monitor

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port tick_1hz, input, 1 bit: one-clock-wide one-second enable.
REQ-004 SHALL have ports Rm, Ym, Gm, Rs, Ys, Gs, W, inputs, 1 bit each: lamp drives from the traffic controller.
REQ-005 SHALL have port err_clear, input, 1 bit: synchronous clear of the sticky error flags.
REQ-006 SHALL have port phase, output, 3 bits: current decoded phase code.
REQ-007 SHALL have port cur_seconds, output, 4 bits: ticks elapsed in the current phase.
REQ-008 SHALL have port last_phase, output, 3 bits: code of the most recently completed phase.
REQ-009 SHALL have port last_seconds, output, 4 bits: duration of the most recently completed phase.
REQ-010 SHALL have port phase_done, output, 1 bit: one-cycle pulse on each phase change.
REQ-011 SHALL have port illegal_combo, output, 1 bit: sticky flag for an illegal lamp combination.
REQ-012 SHALL have port illegal_trans, output, 1 bit: sticky flag for an illegal phase sequence.
REQ-013 SHALL have port walk_count, output, 8 bits: number of walk-phase entries.

Function
REQ-014 SHALL register the seven lamp inputs in a stage-1 register every clock; all decoding SHALL use the registered copy.
REQ-015 SHALL decode the {Rm,Ym,Gm,Rs,Ys,Gs,W} pattern as follows; every other pattern SHALL decode to INV=7:
- AR=0: Rm, Rs
- MG=1: Gm, Rs
- MY=2: Ym, Rs
- SG=3: Rm, Gs
- SY=4: Rm, Ys
- WK=5: Rm, Rs, W
REQ-016 SHALL update the phase register when the decoded code differs from phase; phase therefore lags a lamp change by exactly 2 clocks.
REQ-017 On a phase update, SHALL in the same edge:
- assert phase_done for exactly one cycle;
- load last_phase with the old phase;
- load last_seconds with the old cur_seconds.
REQ-018 SHALL count tick_1hz in cur_seconds, saturating at 15 with no wrap.
REQ-019 When a tick coincides with a phase update, the tick SHALL count for the new phase: cur_seconds loads 1, otherwise 0; last_seconds excludes that tick.
REQ-020 Legal transitions SHALL be exactly:
- MG->MY
- MY->SG, MY->WK
- WK->SG
- SG->SY
- SY->MG
- AR->MG
REQ-021 SHALL set illegal_trans on any other update, except in these unchecked cases:
- updates out of INV;
- the first update after reset.
REQ-022 SHALL set illegal_combo on any update into INV.
REQ-023 SHALL clear both sticky flags on err_clear; if a set condition occurs on the same edge, set SHALL win.
REQ-024 SHALL increment walk_count on each update into WK, saturating at 255.
REQ-025 SHALL hold all outputs stable while the decoded code equals phase, apart from cur_seconds counting.

Reset
REQ-026 While reset is high, SHALL asynchronously force:
- stage-1 lamp register to 0
- phase = AR (0), last_phase = AR (0)
- cur_seconds = 0, last_seconds = 0
- phase_done = 0, illegal_combo = 0, illegal_trans = 0
- walk_count = 0
- first-update flag set
REQ-027 Reset asserted mid-phase SHALL discard all partial counts; operation resumes on the first clock after deassertion.

Verification
REQ-028 Drive MG, MY, SG, SY, MG, each held for 5 ticks -> phase 1,2,3,4,1; each phase_done has last_seconds=5; both error flags stay 0.
REQ-029 Drive MY then WK then SG -> walk_count=1; illegal_trans=0; drive WK 256 times via MY->WK->SG->SY->MG -> walk_count saturates at 255.
REQ-030 Drive MG then SG directly -> illegal_trans=1 two clocks after the lamp change; assert err_clear alone -> flag clears next edge.
REQ-031 Drive Gm and Gs together -> phase=7, illegal_combo=1; then drive MG -> illegal_trans stays 0.
REQ-032 Hold MG for 20 ticks -> cur_seconds saturates at 15; the change to MY with a tick on the same edge -> last_seconds=15, cur_seconds=1.
REQ-033 Assert reset with cur_seconds=7 and walk_count=3 -> all outputs zero immediately, without waiting for a clock edge; the first phase after deassertion (e.g. SG) produces no illegal_trans.
